// File: rtl/dphy_rx_ctrl_pkg.sv
// Shared types and constants for the DPHY RX packet controller.
//   state_e        : controller FSM states
//   SYNC_BYTE      : HS sync pattern expected on every active lane
//   SHORT_PKT_MAX  : largest data type (DI[5:0]) that denotes a short packet
//   HDR_IDX_*      : byte positions of the header fields after the sync byte
package dphy_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TERM    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SYNC    = 3'd3,
    ST_HDR     = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_END     = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_BYTE     = 8'hB8;
  localparam logic [5:0] SHORT_PKT_MAX = 6'h0F;

  localparam int unsigned HDR_BYTES     = 4;
  localparam int unsigned HDR_IDX_DI    = 0;
  localparam int unsigned HDR_IDX_WC_LO = 1;
  localparam int unsigned HDR_IDX_WC_HI = 2;
  localparam int unsigned HDR_IDX_ECC   = 3;

endpackage

// File: rtl/dphy_rx_pkt_ctrl_if.sv
// Bus bundle between the DPHY RX packet controller and its environment.
//   master : the controller (consumes rx_req/ready/data_in, drives the rest)
//   slave  : the environment (DPHY receiver plus packet consumer)
interface dphy_rx_pkt_ctrl_if #(
  parameter int unsigned LANES = 4
);

  logic                 rx_req;
  logic                 ready;
  logic [8*LANES-1:0]   data_in;
  logic                 hs_en;
  logic                 term_en;
  logic                 busy;
  logic                 hdr_valid;
  logic [7:0]           data_id;
  logic [15:0]          word_count;
  logic [7:0]           ecc;
  logic                 pay_valid;
  logic [8*LANES-1:0]   pay_data;
  logic [LANES-1:0]     pay_be;
  logic                 pay_last;
  logic                 done;
  logic                 err_timeout;
  logic                 err_lost;

  modport master (
    input  rx_req, ready, data_in,
    output hs_en, term_en, busy, hdr_valid, data_id, word_count, ecc,
           pay_valid, pay_data, pay_be, pay_last, done, err_timeout, err_lost
  );

  modport slave (
    output rx_req, ready, data_in,
    input  hs_en, term_en, busy, hdr_valid, data_id, word_count, ecc,
           pay_valid, pay_data, pay_be, pay_last, done, err_timeout, err_lost
  );

endinterface

// File: rtl/dphy_rx_hdr_capture.sv
// Assembles the 4-byte packet header (DI, WC lo, WC hi, ECC) from LANES-wide
// byte beats; lane0 of beat idx_i carries header byte idx_i*LANES.
//   clk_byte, reset  : byte clock, synchronous active-high reset
//   data_i           : byte lanes, lane0 in [7:0]
//   sample_en_i      : capture the lanes of this beat
//   idx_i            : header beat index (0 .. 4/LANES-1)
//   data_id_o, word_count_o, ecc_o : registered header fields
//   short_pkt_c_o, word_count_c_o  : combinational view of the fields being
//                                    written this cycle, for the FSM decision
module dphy_rx_hdr_capture
  import dphy_rx_ctrl_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk_byte,
  input  logic               reset,
  input  logic [8*LANES-1:0] data_i,
  input  logic               sample_en_i,
  input  logic [1:0]         idx_i,
  output logic [7:0]         data_id_o,
  output logic [15:0]        word_count_o,
  output logic [7:0]         ecc_o,
  output logic               short_pkt_c_o,
  output logic [15:0]        word_count_c_o
);

  logic [7:0]  data_id_q, data_id_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  ecc_q, ecc_d;

  // Route each lane to the header field its byte position selects.
  always_comb begin
    data_id_d = data_id_q;
    wc_d      = wc_q;
    ecc_d     = ecc_q;
    if (sample_en_i) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        case (32'(idx_i) * LANES + l)
          HDR_IDX_DI:    data_id_d   = data_i[8*l +: 8];
          HDR_IDX_WC_LO: wc_d[7:0]   = data_i[8*l +: 8];
          HDR_IDX_WC_HI: wc_d[15:8]  = data_i[8*l +: 8];
          HDR_IDX_ECC:   ecc_d       = data_i[8*l +: 8];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_byte) begin
    if (reset) begin
      data_id_q <= '0;
      wc_q      <= '0;
      ecc_q     <= '0;
    end else begin
      data_id_q <= data_id_d;
      wc_q      <= wc_d;
      ecc_q     <= ecc_d;
    end
  end

  assign data_id_o      = data_id_q;
  assign word_count_o   = wc_q;
  assign ecc_o          = ecc_q;
  assign short_pkt_c_o  = (data_id_d[5:0] <= SHORT_PKT_MAX);
  assign word_count_c_o = wc_d;

endmodule

// File: rtl/dphy_rx_pkt_ctrl.sv
// DPHY RX packet controller: sequences termination and HS enable, hunts for
// the sync byte, captures the packet header and streams the payload.
//   clk_byte, reset : byte clock, synchronous active-high reset
//   bus (master)    : rx_req/ready/data_in in; hs_en, term_en, busy, header
//                     fields + hdr_valid, payload beats, done and error pulses
module dphy_rx_pkt_ctrl
  import dphy_rx_ctrl_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned T_TERM       = 8,
  parameter int unsigned T_SETTLE     = 16,
  parameter int unsigned SYNC_TIMEOUT = 1024
) (
  input  logic          clk_byte,
  input  logic          reset,
  dphy_rx_pkt_ctrl_if.master bus
);

  localparam int unsigned DW      = 8 * LANES;
  localparam int unsigned HDR_CYC = HDR_BYTES / LANES;
  localparam int unsigned CNT_W   = $clog2(T_TERM + T_SETTLE + SYNC_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        rem_q, rem_d;

  logic               hs_en_q, hs_en_d;
  logic               term_en_q, term_en_d;
  logic               busy_q, busy_d;
  logic               hdr_valid_q, hdr_valid_d;
  logic               pay_valid_q, pay_valid_d;
  logic [DW-1:0]      pay_data_q, pay_data_d;
  logic [LANES-1:0]   pay_be_q, pay_be_d;
  logic               pay_last_q, pay_last_d;
  logic               done_q, done_d;
  logic               err_timeout_q, err_timeout_d;
  logic               err_lost_q, err_lost_d;

  logic               sync_match;
  logic               hdr_sample;
  logic               hdr_last;
  logic               short_pkt_c;
  logic [15:0]        word_count_c;

  // Sync is only recognised when every active lane carries the sync byte.
  always_comb begin
    sync_match = 1'b1;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (bus.data_in[8*l +: 8] != SYNC_BYTE) sync_match = 1'b0;
    end
  end

  assign hdr_sample = (state_q == ST_HDR) && bus.ready;
  assign hdr_last   = (cnt_q == CNT_W'(HDR_CYC - 1));

  dphy_rx_hdr_capture #(.LANES(LANES)) u_hdr (
    .clk_byte       (clk_byte),
    .reset          (reset),
    .data_i         (bus.data_in),
    .sample_en_i    (hdr_sample),
    .idx_i          (2'(cnt_q)),
    .data_id_o      (bus.data_id),
    .word_count_o   (bus.word_count),
    .ecc_o          (bus.ecc),
    .short_pkt_c_o  (short_pkt_c),
    .word_count_c_o (word_count_c)
  );

  // Next state and next register values; cnt restarts on every state change.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    rem_d         = rem_q;
    hdr_valid_d   = 1'b0;
    pay_valid_d   = 1'b0;
    pay_data_d    = '0;
    pay_be_d      = '0;
    pay_last_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_lost_d    = 1'b0;
    done_d        = (state_q == ST_END);

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_req && bus.ready) state_d = ST_TERM;
      end
      ST_TERM: begin
        if (cnt_q == CNT_W'(T_TERM - 1)) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!bus.ready) begin
          err_lost_d = 1'b1;
          state_d    = ST_END;
        end else if (cnt_q == CNT_W'(T_SETTLE - 1)) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        // Ready loss is tested first so it wins over a coincident timeout.
        if (!bus.ready) begin
          err_lost_d = 1'b1;
          state_d    = ST_END;
        end else if (sync_match) begin
          state_d = ST_HDR;
        end else if (cnt_q == CNT_W'(SYNC_TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_END;
        end
      end
      ST_HDR: begin
        if (!bus.ready) begin
          err_lost_d = 1'b1;
          state_d    = ST_END;
        end else if (hdr_last) begin
          hdr_valid_d = 1'b1;
          if (short_pkt_c || (word_count_c == 16'd0)) begin
            state_d = ST_END;
          end else begin
            rem_d   = word_count_c;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!bus.ready) begin
          err_lost_d = 1'b1;
          state_d    = ST_END;
        end else begin
          // Lanes beyond the remaining count hold CRC bytes; blank them.
          pay_valid_d = 1'b1;
          for (int unsigned l = 0; l < LANES; l++) begin
            pay_be_d[l]          = (rem_q > 16'(l));
            pay_data_d[8*l +: 8] = (rem_q > 16'(l)) ? bus.data_in[8*l +: 8] : 8'h00;
          end
          if (rem_q <= 16'(LANES)) begin
            pay_last_d = 1'b1;
            rem_d      = '0;
            state_d    = ST_END;
          end else begin
            rem_d = rem_q - 16'(LANES);
          end
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    busy_d    = (state_d != ST_IDLE);
    term_en_d = state_d inside {ST_TERM, ST_SETTLE, ST_SYNC, ST_HDR, ST_PAYLOAD};
    hs_en_d   = state_d inside {ST_SETTLE, ST_SYNC, ST_HDR, ST_PAYLOAD};
  end

  always_ff @(posedge clk_byte) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      hs_en_q       <= 1'b0;
      term_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      hdr_valid_q   <= 1'b0;
      pay_valid_q   <= 1'b0;
      pay_data_q    <= '0;
      pay_be_q      <= '0;
      pay_last_q    <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_lost_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      hs_en_q       <= hs_en_d;
      term_en_q     <= term_en_d;
      busy_q        <= busy_d;
      hdr_valid_q   <= hdr_valid_d;
      pay_valid_q   <= pay_valid_d;
      pay_data_q    <= pay_data_d;
      pay_be_q      <= pay_be_d;
      pay_last_q    <= pay_last_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_lost_q    <= err_lost_d;
    end
  end

  assign bus.hs_en       = hs_en_q;
  assign bus.term_en     = term_en_q;
  assign bus.busy        = busy_q;
  assign bus.hdr_valid   = hdr_valid_q;
  assign bus.pay_valid   = pay_valid_q;
  assign bus.pay_data    = pay_data_q;
  assign bus.pay_be      = pay_be_q;
  assign bus.pay_last    = pay_last_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_lost    = err_lost_q;

endmodule

// File: tb/tb_dphy_rx_pkt_ctrl.sv
// Directed bench for dphy_rx_pkt_ctrl: a 4-lane instance with default timing
// and a 1-lane instance with short timing. Expected headers and payload beats
// are queued as stimulus is driven and popped by monitors on the falling edge.
module tb_dphy_rx_pkt_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0]  id;
    logic [15:0] wc;
    logic [7:0]  ecc;
  } hdr_t;

  logic clk_byte = 1'b0;
  logic reset;
  always #5 clk_byte = ~clk_byte;

  dphy_rx_pkt_ctrl_if #(.LANES(4)) bus4 ();
  dphy_rx_pkt_ctrl_if #(.LANES(1)) bus1 ();

  dphy_rx_pkt_ctrl #(.LANES(4)) dut4 (
    .clk_byte (clk_byte),
    .reset    (reset),
    .bus      (bus4)
  );

  dphy_rx_pkt_ctrl #(.LANES(1), .T_TERM(3), .T_SETTLE(4), .SYNC_TIMEOUT(20)) dut1 (
    .clk_byte (clk_byte),
    .reset    (reset),
    .bus      (bus1)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  beat_t exp_beat4[$];
  hdr_t  exp_hdr4[$];
  hdr_t  exp_hdr1[$];

  int hdr4 = 0, beats4 = 0, last4 = 0, done4 = 0, lost4 = 0, to4 = 0;
  int hdr1 = 0, beats1 = 0, done1 = 0, lost1 = 0, to1 = 0;
  int done4_cyc = 0, to4_cyc = 0, done1_cyc = 0, hdr1_cyc = 0;
  int s_hdr4, s_beats4, s_last4, s_done4, s_lost4, s_to4;
  int s_hdr1, s_beats1, s_done1, s_lost1, s_to1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_byte);
    #1;
  endtask

  task automatic snap();
    s_hdr4 = hdr4; s_beats4 = beats4; s_last4 = last4;
    s_done4 = done4; s_lost4 = lost4; s_to4 = to4;
    s_hdr1 = hdr1; s_beats1 = beats1; s_done1 = done1;
    s_lost1 = lost1; s_to1 = to1;
  endtask

  always @(posedge clk_byte) cyc++;

  // Scoreboard side for the 4-lane instance.
  always @(negedge clk_byte) begin
    beat_t b;
    hdr_t  h;
    if (bus4.pay_valid) begin
      beats4++;
      if (bus4.pay_last) last4++;
      check("beat4_queued", 64'(exp_beat4.size() != 0), 64'd1);
      if (exp_beat4.size() != 0) begin
        b = exp_beat4.pop_front();
        check("beat4_data", 64'(bus4.pay_data), 64'(b.data));
        check("beat4_be", 64'(bus4.pay_be), 64'(b.be));
        check("beat4_last", 64'(bus4.pay_last), 64'(b.last));
      end
    end
    if (bus4.hdr_valid) begin
      hdr4++;
      check("hdr4_queued", 64'(exp_hdr4.size() != 0), 64'd1);
      if (exp_hdr4.size() != 0) begin
        h = exp_hdr4.pop_front();
        check("hdr4_id", 64'(bus4.data_id), 64'(h.id));
        check("hdr4_wc", 64'(bus4.word_count), 64'(h.wc));
        check("hdr4_ecc", 64'(bus4.ecc), 64'(h.ecc));
      end
    end
    if (bus4.done) begin done4++; done4_cyc = cyc; end
    if (bus4.err_lost) lost4++;
    if (bus4.err_timeout) begin to4++; to4_cyc = cyc; end
  end

  // Scoreboard side for the 1-lane instance.
  always @(negedge clk_byte) begin
    hdr_t h;
    if (bus1.pay_valid) beats1++;
    if (bus1.hdr_valid) begin
      hdr1++;
      hdr1_cyc = cyc;
      check("hdr1_queued", 64'(exp_hdr1.size() != 0), 64'd1);
      if (exp_hdr1.size() != 0) begin
        h = exp_hdr1.pop_front();
        check("hdr1_id", 64'(bus1.data_id), 64'(h.id));
        check("hdr1_wc", 64'(bus1.word_count), 64'(h.wc));
        check("hdr1_ecc", 64'(bus1.ecc), 64'(h.ecc));
      end
    end
    if (bus1.done) begin done1++; done1_cyc = cyc; end
    if (bus1.err_lost) lost1++;
    if (bus1.err_timeout) to1++;
  end

  // Raise rx_req, drop it once busy, return the TERM length seen before hs_en.
  task automatic start4(output int term_len);
    int n;
    bus4.rx_req = 1'b1;
    n = 0;
    while (!bus4.busy && n < 8) begin tick(); n++; end
    check("busy4_rise", 64'(bus4.busy), 64'd1);
    bus4.rx_req = 1'b0;
    n = 0;
    while (!bus4.hs_en && n < 64) begin tick(); n++; end
    term_len = n;
  endtask

  // One 4-lane packet; drop_beat >= 0 pulls ready low on that payload beat.
  task automatic frame4(input logic [7:0] id, input logic [15:0] wc, input int drop_beat);
    int    tl, nb, n;
    logic [31:0] w;
    beat_t e;
    hdr_t  h;
    start4(tl);
    check("term4_len", 64'(tl), 64'd8);
    bus4.data_in = '0;
    repeat (20) tick();
    bus4.data_in = 32'hB8B8_B8B8;
    tick();
    h.id  = id;
    h.wc  = wc;
    h.ecc = id ^ wc[7:0] ^ wc[15:8];
    exp_hdr4.push_back(h);
    bus4.data_in = {h.ecc, wc[15:8], wc[7:0], id};
    tick();
    nb = (int'(wc) + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      if (i == drop_beat) begin
        bus4.ready = 1'b0;
        tick();
        bus4.ready = 1'b1;
        tick();
        check("lost4_idle_in_2", 64'(bus4.busy), 64'd0);
        break;
      end
      w = $urandom();
      for (int l = 0; l < 4; l++) begin
        if (i * 4 + l < int'(wc)) begin
          e.data[8*l +: 8] = w[8*l +: 8];
          e.be[l] = 1'b1;
        end else begin
          e.data[8*l +: 8] = 8'h00;
          e.be[l] = 1'b0;
        end
      end
      e.last = (i == nb - 1);
      exp_beat4.push_back(e);
      bus4.data_in = w;
      tick();
    end
    bus4.data_in = $urandom();
    tick();
    bus4.data_in = '0;
    n = 0;
    while (bus4.busy && n < 8) begin tick(); n++; end
    check("frame4_idle", 64'(bus4.busy), 64'd0);
    repeat (2) tick();
  endtask

  int   n, tl;
  hdr_t h1;

  initial begin
    reset        = 1'b1;
    bus4.rx_req  = 1'b0;
    bus4.ready   = 1'b1;
    bus4.data_in = '0;
    bus1.rx_req  = 1'b0;
    bus1.ready   = 1'b1;
    bus1.data_in = '0;
    repeat (3) tick();

    check("rst_hs_en", 64'(bus4.hs_en), 64'd0);
    check("rst_term_en", 64'(bus4.term_en), 64'd0);
    check("rst_busy", 64'(bus4.busy), 64'd0);
    check("rst_data_id", 64'(bus4.data_id), 64'd0);
    check("rst_word_count", 64'(bus4.word_count), 64'd0);
    check("rst_ecc", 64'(bus4.ecc), 64'd0);
    check("rst_pay_data", 64'(bus4.pay_data), 64'd0);
    check("rst_pay_be", 64'(bus4.pay_be), 64'd0);
    check("rst_done", 64'(bus4.done), 64'd0);
    check("rst1_term_en", 64'(bus1.term_en), 64'd0);
    reset = 1'b0;
    tick();

    // 16-byte long packet: four full beats, last on the fourth
    snap();
    frame4(8'h2A, 16'd16, -1);
    check("p16_hdr_cnt", 64'(hdr4 - s_hdr4), 64'd1);
    check("p16_beats", 64'(beats4 - s_beats4), 64'd4);
    check("p16_last", 64'(last4 - s_last4), 64'd1);
    check("p16_done", 64'(done4 - s_done4), 64'd1);
    check("p16_errs", 64'((lost4 - s_lost4) + (to4 - s_to4)), 64'd0);
    check("p16_word_count", 64'(bus4.word_count), 64'd16);

    // WC=7: two beats, last beat carries three bytes
    snap();
    frame4(8'h24, 16'd7, -1);
    check("p7_beats", 64'(beats4 - s_beats4), 64'd2);
    check("p7_last", 64'(last4 - s_last4), 64'd1);
    check("p7_done", 64'(done4 - s_done4), 64'd1);

    // Long packet with WC=0: header only
    snap();
    frame4(8'h2A, 16'd0, -1);
    check("p0_hdr_cnt", 64'(hdr4 - s_hdr4), 64'd1);
    check("p0_beats", 64'(beats4 - s_beats4), 64'd0);
    check("p0_done", 64'(done4 - s_done4), 64'd1);

    // Ready dropped on beat 2 of 4
    snap();
    frame4(8'h2A, 16'd16, 1);
    check("lost_pulse", 64'(lost4 - s_lost4), 64'd1);
    check("lost_no_last", 64'(last4 - s_last4), 64'd0);
    check("lost_beats", 64'(beats4 - s_beats4), 64'd1);
    check("lost_done", 64'(done4 - s_done4), 64'd1);
    check("lost_no_timeout", 64'(to4 - s_to4), 64'd0);

    // Reset during SETTLE, then a full restart that times out in SYNC
    start4(tl);
    check("term4_len_pre_rst", 64'(tl), 64'd8);
    repeat (3) tick();
    snap();
    reset = 1'b1;
    tick();
    check("midrst_hs_en", 64'(bus4.hs_en), 64'd0);
    check("midrst_term_en", 64'(bus4.term_en), 64'd0);
    check("midrst_busy", 64'(bus4.busy), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("midrst_no_done", 64'(done4 - s_done4), 64'd0);
    check("midrst_no_err", 64'((lost4 - s_lost4) + (to4 - s_to4)), 64'd0);
    start4(tl);
    check("term4_len_post_rst", 64'(tl), 64'd8);
    n = 0;
    while (bus4.busy && n < 1200) begin tick(); n++; end
    check("to4_idle", 64'(bus4.busy), 64'd0);
    repeat (2) tick();
    check("to4_pulse", 64'(to4 - s_to4), 64'd1);
    check("to4_no_lost", 64'(lost4 - s_lost4), 64'd0);
    check("to4_done", 64'(done4 - s_done4), 64'd1);
    check("to4_done_after_err", 64'(done4_cyc - to4_cyc), 64'd1);
    check("to4_hs_en_low", 64'(bus4.hs_en), 64'd0);
    check("to4_no_hdr", 64'(hdr4 - s_hdr4), 64'd0);

    // 1 lane: short packet DI=0x00 with rx_req held high throughout
    snap();
    bus1.rx_req = 1'b1;
    n = 0;
    while (!bus1.busy && n < 8) begin tick(); n++; end
    check("busy1_rise", 64'(bus1.busy), 64'd1);
    n = 0;
    while (!bus1.hs_en && n < 32) begin tick(); n++; end
    check("term1_len", 64'(n), 64'd3);
    bus1.data_in = 8'h00;
    repeat (6) tick();
    bus1.data_in = 8'hB8;
    tick();
    h1 = '{8'h00, 16'h0000, 8'h5A};
    exp_hdr1.push_back(h1);
    bus1.data_in = 8'h00;
    repeat (3) tick();
    bus1.data_in = 8'h5A;
    tick();
    bus1.data_in = 8'h00;
    repeat (4) tick();
    check("short_hdr_cnt", 64'(hdr1 - s_hdr1), 64'd1);
    check("short_no_pay", 64'(beats1 - s_beats1), 64'd0);
    check("short_done", 64'(done1 - s_done1), 64'd1);
    check("short_done_timing", 64'(done1_cyc - hdr1_cyc), 64'd1);
    check("req_held_restart", 64'(bus1.busy), 64'd1);
    bus1.rx_req = 1'b0;
    n = 0;
    while (bus1.busy && n < 100) begin tick(); n++; end
    check("restart1_idle", 64'(bus1.busy), 64'd0);
    repeat (2) tick();
    check("restart1_timeout", 64'(to1 - s_to1), 64'd1);

    // 1 lane: ready loss on the very cycle the SYNC timeout expires
    snap();
    bus1.rx_req = 1'b1;
    n = 0;
    while (!bus1.busy && n < 8) begin tick(); n++; end
    bus1.rx_req = 1'b0;
    n = 0;
    while (!bus1.hs_en && n < 32) begin tick(); n++; end
    check("term1_len_b", 64'(n), 64'd3);
    repeat (23) tick();
    bus1.ready = 1'b0;
    tick();
    bus1.ready = 1'b1;
    repeat (3) tick();
    check("prio_lost", 64'(lost1 - s_lost1), 64'd1);
    check("prio_no_timeout", 64'(to1 - s_to1), 64'd0);
    check("prio_done", 64'(done1 - s_done1), 64'd1);
    check("prio_idle", 64'(bus1.busy), 64'd0);

    check("beat4_q_empty", 64'(exp_beat4.size()), 64'd0);
    check("hdr4_q_empty", 64'(exp_hdr4.size()), 64'd0);
    check("hdr1_q_empty", 64'(exp_hdr1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
